// File: rtl/boot_seq_pkg.sv
// boot_seq_pkg: shared state encoding, stall-mode codes and LFSR constants
// for the core boot sequencer and its stall pattern generator.
package boot_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD_RST,
        ST_PULSE_START,
        ST_RUN
    } boot_state_e;

    localparam logic [1:0] STALL_NONE     = 2'd0;
    localparam logic [1:0] STALL_CONST    = 2'd1;
    localparam logic [1:0] STALL_LFSR     = 2'd2;
    localparam logic [1:0] STALL_PERIODIC = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {^(v & LFSR_TAPS), v[15:1]};
    endfunction

endpackage

// File: rtl/stall_pattern_gen.sv
// stall_pattern_gen: LFSR / periodic stall pattern source; advances only
// while enabled and restarts from a known point on restart.
module stall_pattern_gen
    import boot_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       restart_i,
    input  logic [1:0] mode_i,
    input  logic [7:0] period_i,
    output logic       gen_o
);

    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  cnt_q, cnt_d;

    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        if (restart_i) begin
            lfsr_d = LFSR_SEED;
            cnt_d  = '0;
        end else if (enable_i) begin
            lfsr_d = lfsr_step(lfsr_q);
            // >= also recovers cleanly if the period shrinks below the count.
            cnt_d  = (cnt_q + 8'd1 >= period_i) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
            cnt_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign gen_o = (mode_i == STALL_CONST)
                 | ((mode_i == STALL_LFSR) & lfsr_q[0])
                 | ((mode_i == STALL_PERIODIC) & (period_i != 8'd0) & (cnt_q == 8'd0));

endmodule

// File: rtl/core_boot_sequencer.sv
// core_boot_sequencer: drives per-core reset/start/stall through an
// IDLE -> HOLD_RST -> PULSE_START -> RUN bring-up sequence.
module core_boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int NUM_CORES    = 1,
    parameter int ADDRESS_BITS = 20,
    parameter int RESET_CYCLES = 1,
    parameter int START_CYCLES = 1,
    parameter bit REPORT_EN    = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    boot_req,
    input  logic                    stop_req,
    input  logic [NUM_CORES-1:0]    boot_core_mask,
    input  logic [ADDRESS_BITS-1:0] boot_address,
    input  logic [1:0]              stall_mode,
    input  logic [7:0]              stall_period,
    input  logic                    ext_stall,
    output logic [NUM_CORES-1:0]    core_reset,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [NUM_CORES-1:0]    core_stall,
    output logic [ADDRESS_BITS-1:0] prog_address,
    output logic                    report,
    output logic                    busy,
    output logic                    boot_done
);

    localparam int PHASE_MAX = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam logic [PW-1:0] RST_LAST   = PW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] START_LAST = PW'(START_CYCLES - 1);

    boot_state_e             state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [NUM_CORES-1:0]    mask_q, mask_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [NUM_CORES-1:0]    reset_q, reset_d;
    logic [NUM_CORES-1:0]    start_q, start_d;
    logic [NUM_CORES-1:0]    stall_q, stall_d;
    logic                    report_q, report_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    run_q;
    logic                    in_run, in_seq, accept, gen;

    assign in_run = state_q == ST_RUN;
    assign in_seq = (state_q == ST_HOLD_RST) || (state_q == ST_PULSE_START);
    // Every accepted boot enters HOLD_RST, so acceptance doubles as the generator restart.
    assign accept = boot_req && !stop_req && !in_seq;

    stall_pattern_gen u_gen (
        .clock     (clock),
        .reset     (reset),
        .enable_i  (in_run),
        .restart_i (accept),
        .mode_i    (stall_mode),
        .period_i  (stall_period),
        .gen_o     (gen)
    );

    always_comb begin
        state_d = state_q;
        if (stop_req)
            state_d = ST_IDLE;
        else if (accept)
            state_d = ST_HOLD_RST;
        else if (state_q == ST_HOLD_RST && phase_q == RST_LAST)
            state_d = ST_PULSE_START;
        else if (state_q == ST_PULSE_START && phase_q == START_LAST)
            state_d = ST_RUN;
        phase_d  = (state_d == state_q && in_seq) ? phase_q + 1'b1 : '0;
        mask_d   = accept ? boot_core_mask : mask_q;
        addr_d   = accept ? boot_address : addr_q;
        // Outputs are registered views of the current state, one cycle behind it.
        reset_d  = (state_q == ST_IDLE || state_q == ST_HOLD_RST) ? '1 : ~mask_q;
        start_d  = (state_q == ST_PULSE_START) ? mask_q : '0;
        stall_d  = in_run ? (mask_q & {NUM_CORES{ext_stall | gen}}) : '0;
        report_d = in_run & REPORT_EN;
        busy_d   = in_seq;
        done_d   = in_run & ~run_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            mask_q   <= '0;
            addr_q   <= '0;
            reset_q  <= '1;
            start_q  <= '0;
            stall_q  <= '0;
            report_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            reset_q  <= reset_d;
            start_q  <= start_d;
            stall_q  <= stall_d;
            report_q <= report_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            run_q    <= in_run;
        end
    end

    assign core_reset   = reset_q;
    assign core_start   = start_q;
    assign core_stall   = stall_q;
    assign prog_address = addr_q;
    assign report       = report_q;
    assign busy         = busy_q;
    assign boot_done    = done_q;

endmodule

// File: tb/tb_core_boot_sequencer.sv
// tb_core_boot_sequencer: two sequencer configurations driven by shared
// directed + random stimulus, checked against a timeline-based reference model.
module tb_core_boot_sequencer;

    logic        clock = 1'b0;
    logic        reset, boot_req, stop_req, ext_stall;
    logic [3:0]  mask;
    logic [19:0] addr;
    logic [1:0]  mode;
    logic [7:0]  period;

    logic        reset_a, start_a, stall_a, report_a, busy_a, done_a;
    logic [19:0] prog_a;
    logic [3:0]  reset_b, start_b, stall_b;
    logic        report_b, busy_b, done_b;
    logic [19:0] prog_b;

    int total = 0;
    int bad = 0;
    int pos [2];
    logic [3:0]  mk [2];
    logic [19:0] ad [2];

    always #5 clock = ~clock;

    core_boot_sequencer dut_a (
        .clock(clock), .reset(reset), .boot_req(boot_req), .stop_req(stop_req),
        .boot_core_mask(mask[0]), .boot_address(addr), .stall_mode(mode),
        .stall_period(period), .ext_stall(ext_stall), .core_reset(reset_a),
        .core_start(start_a), .core_stall(stall_a), .prog_address(prog_a),
        .report(report_a), .busy(busy_a), .boot_done(done_a)
    );

    core_boot_sequencer #(.NUM_CORES(4), .RESET_CYCLES(3), .START_CYCLES(2)) dut_b (
        .clock(clock), .reset(reset), .boot_req(boot_req), .stop_req(stop_req),
        .boot_core_mask(mask), .boot_address(addr), .stall_mode(mode),
        .stall_period(period), .ext_stall(ext_stall), .core_reset(reset_b),
        .core_start(start_b), .core_stall(stall_b), .prog_address(prog_b),
        .report(report_b), .busy(busy_b), .boot_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic lfsr_bit(input int n);
        logic [15:0] v = 16'hACE1;
        for (int i = 0; i < n; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v[0];
    endfunction

    function automatic logic gen_ref(input logic [1:0] m, input int n, input logic [7:0] p);
        if (m == 2'd0) return 1'b0;
        if (m == 2'd1) return 1'b1;
        if (m == 2'd2) return lfsr_bit(n);
        return (p != 8'd0) && ((n % int'(p)) == 0);
    endfunction

    // pos = cycles since the boot was accepted (-1 when idle); outputs trail it by one edge.
    task automatic tick();
        logic [3:0]  er [2];
        logic [3:0]  es [2];
        logic [3:0]  est [2];
        logic        erep [2];
        logic        eb [2];
        logic        ed [2];
        for (int d = 0; d < 2; d++) begin
            int r = d ? 3 : 1;
            int s = d ? 2 : 1;
            logic [3:0] w = d ? 4'hF : 4'h1;
            bit run = pos[d] >= r + s;
            if (reset) begin
                er[d] = w; es[d] = 4'h0; est[d] = 4'h0;
                erep[d] = 1'b0; eb[d] = 1'b0; ed[d] = 1'b0;
                pos[d] = -1; mk[d] = 4'h0; ad[d] = 20'h0;
            end else begin
                er[d] = (pos[d] < r) ? w : (~mk[d] & w);
                es[d] = (pos[d] >= r && pos[d] < r + s) ? (mk[d] & w) : 4'h0;
                est[d] = 4'h0;
                if (run) est[d] = mk[d] & w & {4{ext_stall | gen_ref(mode, pos[d] - r - s, period)}};
                erep[d] = run;
                eb[d] = pos[d] >= 0 && pos[d] < r + s;
                ed[d] = pos[d] == r + s;
                if (stop_req) pos[d] = -1;
                else if (boot_req && (pos[d] < 0 || run)) begin
                    pos[d] = 0; mk[d] = mask; ad[d] = addr;
                end else if (pos[d] >= 0) pos[d]++;
            end
        end
        @(posedge clock);
        #1;
        check("a_reset", {31'b0, reset_a}, {28'b0, er[0]});
        check("a_start", {31'b0, start_a}, {28'b0, es[0]});
        check("a_stall", {31'b0, stall_a}, {28'b0, est[0]});
        check("a_addr", {12'b0, prog_a}, {12'b0, ad[0]});
        check("a_report", {31'b0, report_a}, {31'b0, erep[0]});
        check("a_busy", {31'b0, busy_a}, {31'b0, eb[0]});
        check("a_done", {31'b0, done_a}, {31'b0, ed[0]});
        check("b_reset", {28'b0, reset_b}, {28'b0, er[1]});
        check("b_start", {28'b0, start_b}, {28'b0, es[1]});
        check("b_stall", {28'b0, stall_b}, {28'b0, est[1]});
        check("b_addr", {12'b0, prog_b}, {12'b0, ad[1]});
        check("b_report", {31'b0, report_b}, {31'b0, erep[1]});
        check("b_busy", {31'b0, busy_b}, {31'b0, eb[1]});
        check("b_done", {31'b0, done_b}, {31'b0, ed[1]});
    endtask

    initial begin
        reset = 1'b1; boot_req = 1'b0; stop_req = 1'b0; ext_stall = 1'b0;
        mask = 4'b0101; addr = 20'h00040; mode = 2'd3; period = 8'd4;
        pos = '{-1, -1}; mk = '{4'h0, 4'h0}; ad = '{20'h0, 20'h0};
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        boot_req = 1'b1; tick(); boot_req = 1'b0;
        repeat (14) tick();
        ext_stall = 1'b1; repeat (2) tick(); ext_stall = 1'b0;
        check("tp_addr", {12'b0, prog_a}, 32'h40);
        mode = 2'd2; repeat (10) tick();
        boot_req = 1'b1; addr = 20'h12345; tick();
        addr = 20'hABCDE; repeat (2) tick(); boot_req = 1'b0;
        repeat (14) tick();
        check("tp_busy_addr", {12'b0, prog_b}, 32'h12345);
        stop_req = 1'b1; tick(); stop_req = 1'b0;
        mode = 2'd3; period = 8'd0;
        boot_req = 1'b1; tick(); boot_req = 1'b0;
        repeat (10) tick();
        stop_req = 1'b1; boot_req = 1'b1; tick(); stop_req = 1'b0; boot_req = 1'b0;
        repeat (2) tick();
        period = 8'd1;
        boot_req = 1'b1; tick(); boot_req = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (2) tick();
        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 299) == 0;
            stop_req = $urandom_range(0, 59) == 0;
            boot_req = $urandom_range(0, 19) == 0;
            ext_stall = $urandom_range(0, 5) == 0;
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            mask = 4'($urandom);
            addr = 20'($urandom);
            if (pos[0] < 2 && pos[1] < 5 && $urandom_range(0, 3) == 0)
                period = 8'($urandom_range(0, 6));
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_boot_sequencer.md
# core_boot_sequencer

Synthesizable bring-up controller for one or more RISC_V_Core instances. It drives per-core reset, start and stall plus a shared program address through a fixed reset → start → run sequence, and adds a built-in stall-pattern generator for pipeline stress. It sits between the SoC/bench control logic and the cores' `reset`/`start`/`stall_in`/`prog_address`/`report` inputs, and supports multi-core, selective (masked) boot.

## Interface
- `NUM_CORES`, 1: number of cores driven (1..16).
- `ADDRESS_BITS`, 20: width of the program address.
- `RESET_CYCLES`, 1: cycles core reset is held during boot (≥1).
- `START_CYCLES`, 1: width of the start pulse in cycles (≥1).
- `REPORT_EN`, 1: when 1, `report` is asserted during RUN.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `boot_req`  in  1  request a boot sequence; level-sampled.
- `stop_req`  in  1  abort or stop; return all cores to reset.
- `boot_core_mask`  in  NUM_CORES  cores to boot; latched on acceptance.
- `boot_address`  in  ADDRESS_BITS  start PC; latched on acceptance.
- `stall_mode`  in  2  0 = none, 1 = constant, 2 = LFSR, 3 = periodic.
- `stall_period`  in  8  period for mode 3.
- `ext_stall`  in  1  external stall, ORed into generated stall.
- `core_reset`  out  NUM_CORES  per-core reset.
- `core_start`  out  NUM_CORES  per-core start pulse.
- `core_stall`  out  NUM_CORES  per-core stall.
- `prog_address`  out  ADDRESS_BITS  latched boot address.
- `report`  out  1  performance-report enable.
- `busy`  out  1  high in HOLD_RST and PULSE_START.
- `boot_done`  out  1  one-cycle pulse on the first RUN cycle.

## Operation
- States: IDLE, HOLD_RST, PULSE_START, RUN.
- IDLE:
  - `core_reset` is all 1; start, stall and report are 0.
  - `boot_req` goes to HOLD_RST and latches the mask and address.
- HOLD_RST: for RESET_CYCLES cycles, `core_reset[i]` = 1 for all i. Then go to PULSE_START.
- PULSE_START: for START_CYCLES cycles:
  - `core_reset[i]` = ~mask[i];
  - `core_start[i]` = mask[i].
  - Then go to RUN.
- RUN:
  - start = 0; `core_reset[i]` = ~mask[i].
  - `core_stall[i]` = mask[i] & (ext_stall | gen).
  - `report` = REPORT_EN.
  - `boot_req` re-boots: go to HOLD_RST and re-latch the mask and address.
- `stop_req` in any non-IDLE state goes to IDLE. `stop_req` beats `boot_req` when both are asserted.
- `boot_req` is ignored while busy. A mask of all zeros still runs the sequence, but no core is released.
- Stall generator (gen):
  - mode 0: gen = 0.
  - mode 1: gen = 1.
  - mode 2: gen = bit 0 of a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1. The LFSR advances only in RUN and is reseeded on `reset` and on entry to HOLD_RST.
  - mode 3: gen = 1 when the period counter is 0. The counter wraps at `stall_period`−1 and clears on RUN entry. `stall_period` = 0 forces gen = 0; `stall_period` = 1 gives gen = 1 every cycle.
- Outside RUN, `core_stall` = 0 regardless of `ext_stall`.
- Phase counters are sized $clog2(max(RESET_CYCLES, START_CYCLES)+1).

## Timing
- All outputs are registered.
- Reset values: `core_reset` all 1, `core_start` 0, `core_stall` 0, `prog_address` 0, `report` 0, `busy` 0, `boot_done` 0, state IDLE.
- `reset` asserted mid-sequence returns everything to the reset values on the next edge.
- Boot timeline, with `boot_req` sampled at edge k:
  - outputs reflect HOLD_RST from k+1 to k+RESET_CYCLES;
  - start is high from k+RESET_CYCLES+1 for START_CYCLES cycles;
  - `boot_done` pulses at k+RESET_CYCLES+START_CYCLES+1.
- `stop_req` at edge k: `core_reset` is all 1 and `core_stall` is 0 from k+1.
- `stall_mode` and `ext_stall` changes are visible on `core_stall` one cycle after sampling.
- `stall_mode` may change in RUN; the generator state is not reset by a mode change.

## Structure
- Package `boot_seq_pkg` holds:
  - the state enum;
  - `STALL_NONE`/`STALL_CONST`/`STALL_LFSR`/`STALL_PERIODIC` codes;
  - `LFSR_SEED` = 16'hACE1 and the tap mask.
- Sub-module `stall_pattern_gen` contains the LFSR, the period counter and the mode mux. Its inputs are `clock`, `reset`, enable (RUN), restart, mode and period; its output is gen.
- The top level holds the FSM, phase counters, latches and per-core masking.

## Test plan
- Default params, mask = 1, address = 0x00040, `boot_req` pulse at cycle 3: reset high through cycle 4, start high at cycle 5 only, `boot_done` at cycle 6, `prog_address` = 0x00040, `report` = 1.
- NUM_CORES = 4, RESET_CYCLES = 3, START_CYCLES = 2, mask = 4'b0101: cores 0 and 2 start for exactly 2 cycles; cores 1 and 3 stay reset = 1 and start = 0 throughout.
- RUN with mode 3, period 4: `core_stall` follows 1,0,0,0 repeating; period 0 gives all zeros; `ext_stall` = 1 forces 1 on masked cores only.
- RUN with mode 2: the first 8 `core_stall` values match the reference LFSR model from seed 0xACE1. A re-boot reproduces the identical sequence.
- `stop_req` and `boot_req` together in RUN → IDLE next cycle. `reset` in PULSE_START → all reset values next cycle. `boot_req` while busy is ignored, with the latched address unchanged.
